// File: rtl/key_freq_select.sv
// PS/2 set-2 scan-code front end for physics: tracks up to two held note keys and
// publishes their frequency ids with a rate-limited new_f strobe.
module key_freq_select #(
    parameter int unsigned HOLDOFF = 1100000,
    parameter int unsigned HOLD_W  = 21
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] scan_code,
    input  logic       scan_valid,
    output logic [4:0] freq_id1,
    output logic [4:0] freq_id2,
    output logic       new_f
);

    localparam int unsigned ID_W = 5;
    localparam logic [ID_W-1:0] EMPTY = ID_W'(31);
    localparam logic [7:0] CODE_EXT = 8'hE0;
    localparam logic [7:0] CODE_BRK = 8'hF0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BRK,
        ST_EXT,
        ST_EXTBRK
    } state_e;

    state_e            state_q, state_d;
    logic [ID_W-1:0]   s1_q, s1_d, s2_q, s2_d;
    logic [ID_W-1:0]   freq_id1_q, freq_id1_d, freq_id2_q, freq_id2_d;
    logic              new_f_q, new_f_d;
    logic              pending_q, pending_d;
    logic [HOLD_W-1:0] cnt_q, cnt_d;

    logic [ID_W:0]     key_c;
    logic              make_c, brk_c, slot_chg_c, emit_c;

    // Keymap lookup: {hit, id}
    function automatic logic [ID_W:0] map_code(input logic [7:0] code);
        case (code)
            8'h1A: map_code = {1'b1, ID_W'(0)};
            8'h1B: map_code = {1'b1, ID_W'(1)};
            8'h22: map_code = {1'b1, ID_W'(2)};
            8'h23: map_code = {1'b1, ID_W'(3)};
            8'h21: map_code = {1'b1, ID_W'(4)};
            8'h2A: map_code = {1'b1, ID_W'(5)};
            8'h34: map_code = {1'b1, ID_W'(6)};
            8'h32: map_code = {1'b1, ID_W'(7)};
            8'h33: map_code = {1'b1, ID_W'(8)};
            8'h31: map_code = {1'b1, ID_W'(9)};
            8'h3B: map_code = {1'b1, ID_W'(10)};
            8'h3A: map_code = {1'b1, ID_W'(11)};
            8'h15: map_code = {1'b1, ID_W'(12)};
            8'h1E: map_code = {1'b1, ID_W'(13)};
            8'h1D: map_code = {1'b1, ID_W'(14)};
            8'h26: map_code = {1'b1, ID_W'(15)};
            8'h24: map_code = {1'b1, ID_W'(16)};
            8'h2D: map_code = {1'b1, ID_W'(17)};
            8'h2E: map_code = {1'b1, ID_W'(18)};
            8'h2C: map_code = {1'b1, ID_W'(19)};
            8'h36: map_code = {1'b1, ID_W'(20)};
            8'h35: map_code = {1'b1, ID_W'(21)};
            8'h3D: map_code = {1'b1, ID_W'(22)};
            8'h3C: map_code = {1'b1, ID_W'(23)};
            8'h43: map_code = {1'b1, ID_W'(24)};
            default: map_code = {1'b0, EMPTY};
        endcase
    endfunction

    // Prefix parser: only plain make and plain F0-break of mapped keys produce events
    always_comb begin
        state_d = state_q;
        make_c  = 1'b0;
        brk_c   = 1'b0;
        key_c   = map_code(scan_code);
        if (scan_valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (scan_code == CODE_EXT)      state_d = ST_EXT;
                    else if (scan_code == CODE_BRK) state_d = ST_BRK;
                    else                            make_c  = key_c[ID_W];
                end
                ST_BRK: begin
                    brk_c   = key_c[ID_W];
                    state_d = ST_IDLE;
                end
                ST_EXT:    state_d = (scan_code == CODE_BRK) ? ST_EXTBRK : ST_IDLE;
                ST_EXTBRK: state_d = ST_IDLE;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    // Held-key slots: s1 is the older key; a third press evicts the oldest
    always_comb begin
        s1_d = s1_q;
        s2_d = s2_q;
        if (make_c && key_c[ID_W-1:0] != s1_q && key_c[ID_W-1:0] != s2_q) begin
            if (s1_q == EMPTY) begin
                s1_d = key_c[ID_W-1:0];
            end else if (s2_q == EMPTY) begin
                s2_d = key_c[ID_W-1:0];
            end else begin
                s1_d = s2_q;
                s2_d = key_c[ID_W-1:0];
            end
        end else if (brk_c) begin
            if (key_c[ID_W-1:0] == s1_q) begin
                s1_d = s2_q;
                s2_d = EMPTY;
            end else if (key_c[ID_W-1:0] == s2_q) begin
                s2_d = EMPTY;
            end
        end
        slot_chg_c = (s1_d != s1_q) || (s2_d != s2_q);
    end

    // Rate limiter: the reload keeps successive new_f pulses exactly HOLDOFF cycles apart at most rate
    always_comb begin
        emit_c     = pending_q && (cnt_q == '0);
        new_f_d    = emit_c;
        freq_id1_d = emit_c ? s1_q : freq_id1_q;
        freq_id2_d = emit_c ? s2_q : freq_id2_q;
        if (emit_c) begin
            cnt_d     = HOLD_W'(HOLDOFF - 1);
            pending_d = slot_chg_c;
        end else begin
            cnt_d     = (cnt_q != '0) ? cnt_q - HOLD_W'(1) : cnt_q;
            pending_d = pending_q | slot_chg_c;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            s1_q       <= EMPTY;
            s2_q       <= EMPTY;
            freq_id1_q <= EMPTY;
            freq_id2_q <= EMPTY;
            new_f_q    <= 1'b0;
            pending_q  <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            freq_id1_q <= freq_id1_d;
            freq_id2_q <= freq_id2_d;
            new_f_q    <= new_f_d;
            pending_q  <= pending_d;
            cnt_q      <= cnt_d;
        end
    end

    assign freq_id1 = freq_id1_q;
    assign freq_id2 = freq_id2_q;
    assign new_f    = new_f_q;

endmodule
